// File: rtl/vdg_pkg.sv
// Shared definitions for the VDG fetch arbiter: FSM states, display mode table
// and the (AnG, GM) -> {bytes per row, line repeat} decode.
package vdg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    VRD,
    VCAP,
    CRD,
    CCAP,
    CWR
  } state_t;

  localparam logic [5:0] BYTES_32  = 6'd32;
  localparam logic [5:0] BYTES_16  = 6'd16;
  localparam logic [3:0] REPEAT_12 = 4'd12;
  localparam logic [3:0] REPEAT_3  = 4'd3;
  localparam logic [3:0] REPEAT_2  = 4'd2;
  localparam logic [3:0] REPEAT_1  = 4'd1;

  typedef struct packed {
    logic [5:0] bytes;
    logic [3:0] rep;
  } mode_t;

  localparam mode_t MODE_ALPHA = '{bytes: BYTES_32, rep: REPEAT_12};

  function automatic mode_t decode_mode(input logic ang, input logic [2:0] gm);
    mode_t m;
    m = MODE_ALPHA;
    if (ang) begin
      case (gm)
        3'b000:  m = '{bytes: BYTES_16, rep: REPEAT_3};
        3'b001:  m = '{bytes: BYTES_16, rep: REPEAT_3};
        3'b010:  m = '{bytes: BYTES_32, rep: REPEAT_3};
        3'b011:  m = '{bytes: BYTES_16, rep: REPEAT_2};
        3'b100:  m = '{bytes: BYTES_32, rep: REPEAT_2};
        3'b101:  m = '{bytes: BYTES_16, rep: REPEAT_1};
        default: m = '{bytes: BYTES_32, rep: REPEAT_1};
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/vdg_addr_gen.sv
// Display address generator: row base, line repeat count, column and latched
// mode; produces the video fetch address and whether the row still has bytes.
module vdg_addr_gen
  import vdg_pkg::*;
#(
  parameter int unsigned ADDR_W = 16
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              fs_fall,
  input  logic              hs_rise,
  input  logic              issue,
  input  logic              ang,
  input  logic [2:0]        gm,
  input  logic [6:0]        base_addr,
  output logic [ADDR_W-1:0] vid_addr,
  output logic              col_ok
);

  mode_t             mode_q;
  mode_t             mode_new;
  logic [ADDR_W-1:0] row_base;
  logic [3:0]        rep_cnt;
  logic [5:0]        col;
  logic [15:0]       base_full;

  assign mode_new  = decode_mode(ang, gm);
  assign base_full = {base_addr, 9'b0};
  assign vid_addr  = ADDR_W'(base_full) + row_base + ADDR_W'(col);
  assign col_ok    = col < mode_q.bytes;

  // Frame start outranks end of line, which outranks a fetch issue.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      mode_q   <= MODE_ALPHA;
      row_base <= '0;
      rep_cnt  <= '0;
      col      <= '0;
    end else begin
      if (hs_rise) mode_q <= mode_new;
      if (fs_fall) begin
        row_base <= '0;
        rep_cnt  <= '0;
        col      <= '0;
      end else if (hs_rise) begin
        col <= '0;
        if (rep_cnt == mode_q.rep - 4'd1) begin
          rep_cnt  <= '0;
          row_base <= row_base + ADDR_W'(mode_q.bytes);
        end else begin
          rep_cnt <= rep_cnt + 4'd1;
        end
      end else if (issue) begin
        col <= col + 6'd1;
      end
    end
  end

endmodule

// File: rtl/vdg_fetch_arbiter.sv
// Shares the video RAM port between VDG display fetches and CPU accesses;
// video always wins, CPU accesses fill the idle slots.
module vdg_fetch_arbiter
  import vdg_pkg::*;
#(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned VOVR_EN = 1
) (
  input  logic              Clk,
  input  logic              Resetn,
  input  logic              FSn,
  input  logic              HSn,
  input  logic              DA0,
  input  logic              AnG,
  input  logic [2:0]        GM,
  input  logic [6:0]        BaseAddr,
  input  logic              CpuReq,
  input  logic              CpuWe,
  input  logic [ADDR_W-1:0] CpuAddr,
  input  logic [7:0]        CpuWData,
  output logic              CpuAck,
  output logic [7:0]        CpuRData,
  output logic [ADDR_W-1:0] MemAddr,
  output logic              MemOe,
  output logic              MemWe,
  output logic [7:0]        MemWData,
  input  logic [7:0]        MemRData,
  output logic [7:0]        VData,
  output logic              VValid,
  output logic              VOvr
);

  state_t            state_q, state_d;
  logic              fsn_q, fsn_p, hsn_q, hsn_p, da0_q, da0_p;
  logic              fs_fall, hs_rise, da0_rise;
  logic              cpu_req_q;
  logic              vpend;
  logic              col_ok;
  logic [ADDR_W-1:0] vid_addr;

  assign fs_fall  = fsn_p & ~fsn_q;
  assign hs_rise  = ~hsn_p & hsn_q;
  assign da0_rise = da0_q & ~da0_p;

  // Sync inputs idle high so reset release does not fake an edge.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      fsn_q     <= 1'b1;
      fsn_p     <= 1'b1;
      hsn_q     <= 1'b1;
      hsn_p     <= 1'b1;
      da0_q     <= 1'b0;
      da0_p     <= 1'b0;
      cpu_req_q <= 1'b0;
    end else begin
      fsn_q     <= FSn;
      fsn_p     <= fsn_q;
      hsn_q     <= HSn;
      hsn_p     <= hsn_q;
      da0_q     <= DA0;
      da0_p     <= da0_q;
      cpu_req_q <= CpuReq;
    end
  end

  vdg_addr_gen #(
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk      (Clk),
    .resetn   (Resetn),
    .fs_fall  (fs_fall),
    .hs_rise  (hs_rise),
    .issue    (state_q == VRD),
    .ang      (AnG),
    .gm       (GM),
    .base_addr(BaseAddr),
    .vid_addr (vid_addr),
    .col_ok   (col_ok)
  );

  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      vpend <= 1'b0;
      VOvr  <= 1'b0;
    end else begin
      if (state_q == VRD) vpend <= 1'b0;
      if (da0_rise) begin
        if (vpend) begin
          if (VOVR_EN != 0) VOvr <= 1'b1;
        end else if (col_ok) begin
          vpend <= 1'b1;
        end
      end
      if (fs_fall) VOvr <= 1'b0;
    end
  end

  // A CPU start is held off while a DA0 edge is in flight and for the IDLE
  // cycle that shows CpuAck, so the requester can drop CpuReq in time.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (vpend) state_d = VRD;
        else if (cpu_req_q && !CpuAck && !da0_rise) state_d = CpuWe ? CWR : CRD;
      end
      VRD:     state_d = VCAP;
      CRD:     state_d = CCAP;
      VCAP,
      CCAP,
      CWR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // RAM controls are registered from the next state so they align with it.
  always_ff @(posedge Clk) begin
    if (!Resetn) begin
      state_q  <= IDLE;
      MemAddr  <= '0;
      MemOe    <= 1'b0;
      MemWe    <= 1'b0;
      MemWData <= '0;
      VData    <= '0;
      VValid   <= 1'b0;
      CpuRData <= '0;
      CpuAck   <= 1'b0;
    end else begin
      state_q  <= state_d;
      MemOe    <= (state_d == VRD) || (state_d == CRD);
      MemWe    <= (state_d == CWR);
      MemWData <= (state_d == CWR) ? CpuWData : '0;
      case (state_d)
        VRD:      MemAddr <= vid_addr;
        CRD, CWR: MemAddr <= CpuAddr;
        default:  MemAddr <= '0;
      endcase
      VValid <= (state_q == VCAP);
      if (state_q == VCAP) VData <= MemRData;
      CpuAck <= (state_q == CCAP) || (state_q == CWR);
      if (state_q == CCAP) CpuRData <= MemRData;
    end
  end

endmodule

// File: tb/tb_vdg_fetch_arbiter.sv
// Directed bench for vdg_fetch_arbiter: mode table vectors plus hand-written
// CPU/video interleave, overrun and reset sequences against a simple RAM model.
module tb_vdg_fetch_arbiter;

  logic        Clk = 1'b0;
  logic        Resetn = 1'b0;
  logic        FSn = 1'b1, HSn = 1'b1, DA0 = 1'b0;
  logic        AnG = 1'b0;
  logic [2:0]  GM = 3'b000;
  logic [6:0]  BaseAddr = 7'h04;
  logic        CpuReq = 1'b0, CpuWe = 1'b0;
  logic [15:0] CpuAddr = 16'h0000;
  logic [7:0]  CpuWData = 8'h00;
  logic        CpuAck;
  logic [7:0]  CpuRData;
  logic [15:0] MemAddr;
  logic        MemOe, MemWe;
  logic [7:0]  MemWData;
  logic [7:0]  MemRData = 8'h00;
  logic [7:0]  VData;
  logic        VValid, VOvr;

  vdg_fetch_arbiter #(.ADDR_W(16), .VOVR_EN(1)) dut (
    .Clk(Clk), .Resetn(Resetn), .FSn(FSn), .HSn(HSn), .DA0(DA0),
    .AnG(AnG), .GM(GM), .BaseAddr(BaseAddr),
    .CpuReq(CpuReq), .CpuWe(CpuWe), .CpuAddr(CpuAddr), .CpuWData(CpuWData),
    .CpuAck(CpuAck), .CpuRData(CpuRData),
    .MemAddr(MemAddr), .MemOe(MemOe), .MemWe(MemWe), .MemWData(MemWData),
    .MemRData(MemRData), .VData(VData), .VValid(VValid), .VOvr(VOvr)
  );

  always #5 Clk = ~Clk;

  function automatic logic [7:0] rd_model(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h3C;
  endfunction

  always @(posedge Clk) MemRData <= MemOe ? rd_model(MemAddr) : 8'h00;

  bit both_seen = 1'b0;
  always @(negedge Clk) if (MemOe && MemWe) both_seen = 1'b1;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic logic [63:0] all_outputs();
    return 64'({CpuAck, CpuRData, MemAddr, MemOe, MemWe, MemWData, VData, VValid, VOvr});
  endfunction

  task automatic hs_pulse();
    HSn = 1'b0;
    repeat (3) @(negedge Clk);
    HSn = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  task automatic fs_pulse();
    FSn = 1'b0;
    repeat (3) @(negedge Clk);
    FSn = 1'b1;
    repeat (3) @(negedge Clk);
  endtask

  // One DA0 pulse in an 8-clock window; i counts negedges after the first sampling edge.
  task automatic da0_fetch(output bit got_oe, output logic [15:0] oe_addr,
                           output bit got_vv, output logic [7:0] vd,
                           output int oe_c, output int vv_c);
    got_oe = 1'b0; got_vv = 1'b0; oe_addr = '0; vd = '0; oe_c = -1; vv_c = -1;
    DA0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (i == 2) DA0 = 1'b0;
      if (MemOe && !got_oe) begin got_oe = 1'b1; oe_addr = MemAddr; oe_c = i; end
      if (VValid && !got_vv) begin got_vv = 1'b1; vd = VData; vv_c = i; end
    end
  endtask

  task automatic cpu_op(input logic we, input logic [15:0] a, input logic [7:0] d, input bit with_da0,
                        output int oe_c, output logic [15:0] oe_addr,
                        output int we_c, output logic [15:0] we_addr, output logic [7:0] we_data,
                        output int ack_c, output logic [7:0] rdata, output int ack_n);
    oe_c = -1; we_c = -1; ack_c = -1; ack_n = 0;
    oe_addr = '0; we_addr = '0; we_data = '0; rdata = '0;
    CpuWe = we; CpuAddr = a; CpuWData = d; CpuReq = 1'b1;
    if (with_da0) DA0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      if (i == 2) DA0 = 1'b0;
      if (MemOe && oe_c < 0) begin oe_c = i; oe_addr = MemAddr; end
      if (MemWe && we_c < 0) begin we_c = i; we_addr = MemAddr; we_data = MemWData; end
      if (CpuAck) begin
        ack_n++;
        if (ack_c < 0) begin ack_c = i; rdata = CpuRData; end
        CpuReq = 1'b0;
      end
    end
    CpuReq = 1'b0;
  endtask

  task automatic run_lines(input int nlines, input int per_line, input logic [15:0] start,
                           input int bytes, input int rep);
    bit got_oe, got_vv;
    logic [15:0] oa, exp;
    logic [7:0] vd;
    int oc, vc;
    for (int ln = 0; ln < nlines; ln++) begin
      if (ln > 0) hs_pulse();
      for (int c = 0; c < per_line; c++) begin
        da0_fetch(got_oe, oa, got_vv, vd, oc, vc);
        exp = start + 16'((ln / rep) * bytes + c);
        check($sformatf("line%0d_col%0d_addr", ln, c), oa, exp);
        check($sformatf("line%0d_col%0d_vdata", ln, c), vd, rd_model(exp));
        if (ln == 0 && c == 0) begin
          check("first_fetch_oe_latency", oc, 2);
          check("first_fetch_vvalid_latency", vc, 4);
        end
      end
    end
  endtask

  typedef struct {
    logic        ang;
    logic [2:0]  gm;
    logic [6:0]  base;
    int          bytes;
    int          rep;
  } vec_t;

  vec_t vecs[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit got_oe, got_vv;
    logic [15:0] oa, first_addr, base16;
    logic [7:0] vd, wd, rd;
    logic [15:0] wa;
    int oc, vc, wc, ac, an, n_vv, n_oe;
    bit ack_seen, oe_seen;

    vecs[0] = '{ang: 1'b0, gm: 3'b000, base: 7'h04, bytes: 32, rep: 12};
    vecs[1] = '{ang: 1'b1, gm: 3'b000, base: 7'h04, bytes: 16, rep: 3};
    vecs[2] = '{ang: 1'b1, gm: 3'b001, base: 7'h10, bytes: 16, rep: 3};
    vecs[3] = '{ang: 1'b1, gm: 3'b010, base: 7'h22, bytes: 32, rep: 3};
    vecs[4] = '{ang: 1'b1, gm: 3'b011, base: 7'h7F, bytes: 16, rep: 2};
    vecs[5] = '{ang: 1'b1, gm: 3'b100, base: 7'h01, bytes: 32, rep: 2};
    vecs[6] = '{ang: 1'b1, gm: 3'b101, base: 7'h40, bytes: 16, rep: 1};
    vecs[7] = '{ang: 1'b1, gm: 3'b110, base: 7'h04, bytes: 32, rep: 1};
    vecs[8] = '{ang: 1'b1, gm: 3'b111, base: 7'h04, bytes: 32, rep: 1};

    repeat (3) @(negedge Clk);
    check("reset_outputs", all_outputs(), 64'h0);
    Resetn = 1'b1;
    @(negedge Clk);

    // Mode table: 40 DA0 edges on the first line, then one fetch per line until the row advances.
    for (int v = 0; v < 9; v++) begin
      AnG = vecs[v].ang; GM = vecs[v].gm; BaseAddr = vecs[v].base;
      base16 = {vecs[v].base, 9'b0};
      hs_pulse();
      fs_pulse();
      n_vv = 0; first_addr = '0;
      for (int e = 0; e < 40; e++) begin
        da0_fetch(got_oe, oa, got_vv, vd, oc, vc);
        if (e == 0) first_addr = oa;
        if (got_vv) n_vv++;
      end
      check($sformatf("vec%0d_vvalid_count", v), n_vv, vecs[v].bytes);
      check($sformatf("vec%0d_first_addr", v), first_addr, base16);
      check($sformatf("vec%0d_vdata_hold", v), VData, rd_model(base16 + 16'(vecs[v].bytes - 1)));
      for (int k = 1; k <= vecs[v].rep; k++) begin
        hs_pulse();
        da0_fetch(got_oe, oa, got_vv, vd, oc, vc);
        check($sformatf("vec%0d_line%0d_addr", v, k), oa,
              (k == vecs[v].rep) ? base16 + 16'(vecs[v].bytes) : base16);
      end
    end

    // CG1 and alpha, every fetch of every line.
    BaseAddr = 7'h04; AnG = 1'b1; GM = 3'b000;
    hs_pulse(); fs_pulse();
    run_lines(4, 16, 16'h0800, 16, 3);
    AnG = 1'b0;
    hs_pulse(); fs_pulse();
    run_lines(13, 32, 16'h0800, 32, 12);

    // Unobstructed CPU write and read.
    fs_pulse();
    cpu_op(1'b1, 16'h4321, 8'h5A, 1'b0, oc, oa, wc, wa, wd, ac, rd, an);
    check("wr_memwe_cycle", wc, 1);
    check("wr_addr", wa, 16'h4321);
    check("wr_data", wd, 8'h5A);
    check("wr_ack_cycle", ac, 2);
    check("wr_ack_count", an, 1);
    check("wr_no_oe", oc, -1);
    cpu_op(1'b0, 16'h4321, 8'h00, 1'b0, oc, oa, wc, wa, wd, ac, rd, an);
    check("rd_memoe_cycle", oc, 1);
    check("rd_addr", oa, 16'h4321);
    check("rd_ack_cycle", ac, 3);
    check("rd_data", rd, rd_model(16'h4321));
    check("rd_ack_count", an, 1);

    // Write and DA0 edge in the same cycle: video first.
    cpu_op(1'b1, 16'h1234, 8'hA5, 1'b1, oc, oa, wc, wa, wd, ac, rd, an);
    check("sim_video_oe_cycle", oc, 2);
    check("sim_video_addr", oa, 16'h0800);
    check("sim_memwe_cycle", wc, 5);
    check("sim_wr_addr", wa, 16'h1234);
    check("sim_wr_data", wd, 8'hA5);
    check("sim_ack_cycle", ac, 6);
    check("sim_ack_count", an, 1);

    // Overrun: two DA0 edges two clocks apart while a CPU read is in progress.
    fs_pulse();
    check("vovr_before", VOvr, 1'b0);
    CpuWe = 1'b0; CpuAddr = 16'h2000; CpuReq = 1'b1;
    n_oe = 0; n_vv = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge Clk);
      if (i == 0) DA0 = 1'b1;
      if (i == 1) DA0 = 1'b0;
      if (i == 2) DA0 = 1'b1;
      if (i == 3) DA0 = 1'b0;
      if (MemOe) n_oe++;
      if (VValid) n_vv++;
      if (CpuAck) CpuReq = 1'b0;
    end
    CpuReq = 1'b0;
    check("ovr_mem_reads", n_oe, 2);
    check("ovr_vvalid_count", n_vv, 1);
    check("ovr_flag_set", VOvr, 1'b1);
    repeat (5) @(negedge Clk);
    check("ovr_flag_sticky", VOvr, 1'b1);
    fs_pulse();
    check("ovr_flag_cleared", VOvr, 1'b0);

    // Give RowBase a nonzero value, then reset during CCAP.
    AnG = 1'b1; GM = 3'b110;
    hs_pulse(); fs_pulse(); hs_pulse();
    da0_fetch(got_oe, oa, got_vv, vd, oc, vc);
    check("pre_reset_rowbase_addr", oa, 16'h0820);
    CpuWe = 1'b0; CpuAddr = 16'h3456; CpuReq = 1'b1;
    ack_seen = 1'b0; oe_seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge Clk);
      if (CpuAck) ack_seen = 1'b1;
      if (i == 1 && MemOe) oe_seen = 1'b1;
      if (i == 2) Resetn = 1'b0;
      if (i == 3) begin
        check("reset_mid_outputs", all_outputs(), 64'h0);
        CpuReq = 1'b0;
      end
    end
    check("reset_mid_read_started", oe_seen, 1'b1);
    check("reset_mid_no_ack", ack_seen, 1'b0);
    Resetn = 1'b1;
    repeat (2) @(negedge Clk);
    da0_fetch(got_oe, oa, got_vv, vd, oc, vc);
    check("post_reset_rowbase_addr", oa, 16'h0800);
    check("post_reset_vdata", vd, rd_model(16'h0800));

    check("oe_we_exclusive", both_seen, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
